csr_read_pipe: RTL and testbench

- Two-stage pipeline that feeds the CSR counter block and consumes its result.
- Stage 1 decodes SYSTEM instructions and presents a registered csrop address to the CSR block.
- Stage 2 captures the CSR block's combinational read data (csr_rdata) and hands a writeback packet (rd, data, write-enable) to the register-file writeback path.
- It shares the CSR block's stall/flush semantics so that a counter read and the instret accounting stay coherent.

---
 rtl/csr_read_pipe_if.sv | 29 ++
 rtl/csr_read_pipe.sv | 143 ++++++++++++++
 tb/tb_csr_read_pipe.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_read_pipe_if.sv
// Bus between the SYSTEM-instruction read pipe, its upstream decode stage,
// the CSR counter block and the register-file writeback path.
interface csr_read_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [31:0]       in_inst;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] csr_rdata;
    logic [11:0]       csrop;
    logic              out_valid;
    logic [4:0]        out_rd;
    logic [DATA_W-1:0] out_data;
    logic              out_we;
    logic              out_illegal;

    // The pipe itself
    modport slave (
        input  in_valid, in_inst, stall, flush, csr_rdata,
        output csrop, out_valid, out_rd, out_data, out_we, out_illegal
    );

    // Environment: upstream decode, CSR block and writeback
    modport master (
        output in_valid, in_inst, stall, flush, csr_rdata,
        input  csrop, out_valid, out_rd, out_data, out_we, out_illegal
    );
endinterface

// File: rtl/csr_read_pipe.sv
// Two-stage CSR counter read pipe. Stage 1 decodes SYSTEM instructions and
// presents a registered CSR address to the counter block; stage 2 captures
// the block's combinational read data and forms the writeback packet.
// Stall and flush follow the counter block so counter reads and instret
// accounting stay coherent.
module csr_read_pipe #(
    parameter int ENABLE_H = 1,
    parameter int DATA_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    csr_read_pipe_if.slave bus
);

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_CSRRS   = 3'b010;

    // Readable counter addresses; high halves only when enabled.
    function automatic logic counter_hit(input logic [11:0] addr);
        logic hit;
        case (addr)
            12'hC00, 12'hC02: hit = 1'b1;
            12'hC80, 12'hC82: hit = (ENABLE_H != 0);
            default:          hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Decode of the incoming instruction
    logic        dec_sys;
    logic        dec_rd_csr;
    logic        dec_hit;
    logic        dec_csr;
    logic        dec_illegal;
    logic [4:0]  dec_rd;
    logic [11:0] dec_addr;

    // Stage-1 state
    logic        s1_valid_q,   s1_valid_d;
    logic [4:0]  s1_rd_q,      s1_rd_d;
    logic [11:0] s1_addr_q,    s1_addr_d;
    logic        s1_csr_q,     s1_csr_d;
    logic        s1_illegal_q, s1_illegal_d;
    logic [11:0] csrop_q,      csrop_d;

    // Stage-2 state
    logic              out_valid_q,   out_valid_d;
    logic [4:0]        out_rd_q,      out_rd_d;
    logic [DATA_W-1:0] out_data_q,    out_data_d;
    logic              out_csr_q,     out_csr_d;
    logic              out_illegal_q, out_illegal_d;

    // Classify the instruction word: counter read, illegal CSR access or neither
    always_comb begin
        dec_sys     = (bus.in_inst[6:0] == OPC_SYSTEM);
        dec_rd      = bus.in_inst[11:7];
        dec_addr    = bus.in_inst[31:20];
        dec_rd_csr  = dec_sys && (bus.in_inst[14:12] == F3_CSRRS)
                              && (bus.in_inst[19:15] == 5'd0);
        dec_hit     = counter_hit(dec_addr);
        dec_csr     = dec_rd_csr && dec_hit;
        dec_illegal = dec_sys && (bus.in_inst[14:12] != 3'd0) && !dec_csr;
    end

    // Next state for both stages: flush beats stall, stall freezes everything
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_rd_d       = s1_rd_q;
        s1_addr_d     = s1_addr_q;
        s1_csr_d      = s1_csr_q;
        s1_illegal_d  = s1_illegal_q;
        csrop_d       = csrop_q;
        out_valid_d   = out_valid_q;
        out_rd_d      = out_rd_q;
        out_data_d    = out_data_q;
        out_csr_d     = out_csr_q;
        out_illegal_d = out_illegal_q;

        if (bus.flush) begin
            // Only the valids matter; csrop returns to the idle address so
            // the counter block sees no read for a dead slot.
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            csrop_d     = 12'h000;
        end else if (!bus.stall) begin
            s1_valid_d    = bus.in_valid;
            s1_rd_d       = dec_rd;
            s1_addr_d     = dec_addr;
            s1_csr_d      = dec_csr;
            s1_illegal_d  = dec_illegal;
            // Registered copy of the address so the CSR block sees a
            // glitch-free value for the whole stage-1 cycle.
            csrop_d       = (bus.in_valid && dec_csr) ? dec_addr : 12'h000;

            out_valid_d   = s1_valid_q;
            out_rd_d      = s1_rd_q;
            out_csr_d     = s1_csr_q;
            out_illegal_d = s1_illegal_q;
            out_data_d    = (s1_valid_q && s1_csr_q) ? bus.csr_rdata : '0;
        end
    end

    // Pipeline registers; reset drops any in-flight packet at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q    <= 1'b0;
            s1_rd_q       <= 5'd0;
            s1_addr_q     <= 12'h000;
            s1_csr_q      <= 1'b0;
            s1_illegal_q  <= 1'b0;
            csrop_q       <= 12'h000;
            out_valid_q   <= 1'b0;
            out_rd_q      <= 5'd0;
            out_data_q    <= '0;
            out_csr_q     <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_rd_q       <= s1_rd_d;
            s1_addr_q     <= s1_addr_d;
            s1_csr_q      <= s1_csr_d;
            s1_illegal_q  <= s1_illegal_d;
            csrop_q       <= csrop_d;
            out_valid_q   <= out_valid_d;
            out_rd_q      <= out_rd_d;
            out_data_q    <= out_data_d;
            out_csr_q     <= out_csr_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // Writeback only for a legal counter read with a real destination
    always_comb begin
        bus.out_we = out_valid_q && out_csr_q && !out_illegal_q && (out_rd_q != 5'd0);
    end

    assign bus.csrop       = csrop_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_csr_read_pipe.sv
// Bench for csr_read_pipe: one instance with high-half counters enabled and
// one without, driven by the same instruction stream and checked each cycle
// against a transaction-level model of the two pipeline slots.
module tb_csr_read_pipe;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [11:0] addr;
        logic        rdcsr;
        logic        ill;
        logic [31:0] data;
    } pkt_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        stall;
    logic        flush;
    logic [31:0] noise;
    logic        fixed_en;
    logic [31:0] fixed_val;

    int n_vec;
    int n_err;

    pkt_t m1 [2];
    pkt_t m2 [2];

    csr_read_pipe_if #(.DATA_W(DATA_W)) bus_a ();
    csr_read_pipe_if #(.DATA_W(DATA_W)) bus_b ();

    // Counter block stand-in: address 0 reads 0, otherwise a per-cycle value
    function automatic logic [31:0] csr_resp(input logic [11:0] a, input logic [31:0] nz,
                                             input logic fe, input logic [31:0] fv);
        if (a == 12'h000) return 32'h0;
        if (fe) return fv;
        return {a, 20'h0} ^ nz;
    endfunction

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_inst   = in_inst;
    assign bus_a.stall     = stall;
    assign bus_a.flush     = flush;
    assign bus_a.csr_rdata = csr_resp(bus_a.csrop, noise, fixed_en, fixed_val);
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_inst   = in_inst;
    assign bus_b.stall     = stall;
    assign bus_b.flush     = flush;
    assign bus_b.csr_rdata = csr_resp(bus_b.csrop, noise, fixed_en, fixed_val);

    csr_read_pipe #(.ENABLE_H(1), .DATA_W(DATA_W)) dut_a (.clk(clk), .rst(rst_n), .bus(bus_a));
    csr_read_pipe #(.ENABLE_H(0), .DATA_W(DATA_W)) dut_b (.clk(clk), .rst(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Instruction meaning straight from the ISA rules
    function automatic pkt_t decode(input logic [31:0] inst, input logic v, input bit en_h);
        pkt_t p;
        bit   sys;
        bit   is_read;
        bit   listed;
        sys     = (inst[6:0] == 7'h73);
        is_read = sys && (inst[14:12] == 3'd2) && (inst[19:15] == 5'd0);
        listed  = (inst[31:20] inside {12'hC00, 12'hC02}) ||
                  (en_h && (inst[31:20] inside {12'hC80, 12'hC82}));
        p       = '0;
        p.v     = v;
        p.rd    = inst[11:7];
        p.addr  = inst[31:20];
        p.rdcsr = is_read && listed;
        p.ill   = sys && (inst[14:12] != 3'd0) && !p.rdcsr;
        return p;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m1[k] = '0;
            m2[k] = '0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            pkt_t nx;
            if (flush) begin
                m1[k].v = 1'b0;
                m2[k].v = 1'b0;
            end else if (!stall) begin
                nx      = m1[k];
                nx.data = (m1[k].v && m1[k].rdcsr) ? csr_resp(m1[k].addr, noise, fixed_en, fixed_val) : 32'h0;
                m2[k]   = nx;
                m1[k]   = decode(in_inst, in_valid, (k == 0));
            end
        end
    endtask

    task automatic check_dut(input string nm, input int k, input logic ov, input logic [4:0] ord,
                             input logic [31:0] od, input logic owe, input logic oil,
                             input logic [11:0] cop);
        pkt_t  e;
        logic  we_exp;
        logic [11:0] cop_exp;
        e       = m2[k];
        we_exp  = e.v && e.rdcsr && !e.ill && (e.rd != 5'd0);
        cop_exp = (m1[k].v && m1[k].rdcsr) ? m1[k].addr : 12'h000;
        chk({nm, ".out_valid"}, ov, e.v);
        chk({nm, ".out_we"}, owe, we_exp);
        chk({nm, ".csrop"}, cop, cop_exp);
        if (e.v || !rst_n) begin
            chk({nm, ".out_rd"}, ord, e.rd);
            chk({nm, ".out_data"}, od, e.data);
            chk({nm, ".out_illegal"}, oil, e.ill);
        end
    endtask

    task automatic check_all();
        check_dut("A", 0, bus_a.out_valid, bus_a.out_rd, bus_a.out_data, bus_a.out_we,
                  bus_a.out_illegal, bus_a.csrop);
        check_dut("B", 1, bus_b.out_valid, bus_b.out_rd, bus_b.out_data, bus_b.out_we,
                  bus_b.out_illegal, bus_b.csrop);
    endtask

    // Called just after a falling edge: drive, clock, then check
    task automatic step(input logic v, input logic [31:0] inst, input logic st, input logic fl);
        in_valid = v;
        in_inst  = inst;
        stall    = st;
        flush    = fl;
        noise    = $urandom;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse launched in the low phase of the clock
    task automatic async_reset(input int cycles);
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [11:0] a;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        logic [4:0]  rd;
        if ($urandom_range(0, 9) < 2) return $urandom;
        case ($urandom_range(0, 6))
            0:       a = 12'hC00;
            1:       a = 12'hC02;
            2:       a = 12'hC80;
            3:       a = 12'hC82;
            4:       a = 12'h300;
            5:       a = 12'hC01;
            default: a = 12'($urandom);
        endcase
        f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
        rs1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        return {a, rs1, f3, rd, 7'h73};
    endfunction

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        stall     = 1'b0;
        flush     = 1'b0;
        noise     = 32'h0;
        fixed_en  = 1'b0;
        fixed_val = 32'h0;
        model_clear();

        // Reset then idle
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // rdcycle a0 with the counter reading 0x1234
        fixed_en  = 1'b1;
        fixed_val = 32'h1234;
        step(1'b1, 32'hC0002573, 1'b0, 1'b0);
        chk("rdcycle.csrop", bus_a.csrop, 12'hC00);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rdcycle.data", bus_a.out_data, 32'h1234);
        chk("rdcycle.rd", bus_a.out_rd, 5'd10);
        chk("rdcycle.we", bus_a.out_we, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Stall hold; the instruction offered during stall is dropped
        step(1'b1, 32'hC0002573, 1'b0, 1'b0);
        fixed_val = 32'h9999;
        step(1'b1, 32'hC0202DF3, 1'b1, 1'b0);
        step(1'b1, 32'hC0202DF3, 1'b1, 1'b0);
        chk("stall.csrop", bus_a.csrop, 12'hC00);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall.data", bus_a.out_data, 32'h9999);
        fixed_val = 32'h5555;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stall.hold", bus_a.out_data, 32'h9999);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Flush beats stall and in_valid with both stages occupied
        fixed_en = 1'b0;
        step(1'b1, 32'hC0002573, 1'b0, 1'b0);
        step(1'b1, 32'hC02025F3, 1'b0, 1'b0);
        step(1'b1, 32'hC0002573, 1'b1, 1'b1);
        chk("flush.valid", bus_a.out_valid, 1'b0);
        chk("flush.csrop", bus_a.csrop, 12'h000);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush.drop", bus_a.out_valid, 1'b0);

        // Illegal accesses: high half on the instance without it, then mstatus
        step(1'b1, 32'hC8002573, 1'b0, 1'b0);
        step(1'b1, 32'h30002573, 1'b0, 1'b0);
        chk("illegal.h.ill", bus_b.out_illegal, 1'b1);
        chk("illegal.h.we", bus_b.out_we, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("illegal.mstatus.ill", bus_a.out_illegal, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // rdinstret then rdinstreth, reset while the second sits in stage 1
        step(1'b1, 32'hC0202573, 1'b0, 1'b0);
        step(1'b1, 32'hC82025F3, 1'b0, 1'b0);
        chk("b2b.first.valid", bus_a.out_valid, 1'b1);
        async_reset(2);
        chk("b2b.reset.valid", bus_a.out_valid, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset($urandom_range(0, 2));
            end else begin
                step(($urandom_range(0, 3) != 0), rand_inst(),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
